// File: rtl/peridot_phy_txd_fifo.sv
// UART transmit PHY with input FIFO and a build-time frame format (data bits, parity, stop bits).
// Define PERIDOT_TXD_CTS_EN to add the cts_n flow-control input.
module peridot_phy_txd_fifo #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUDRATE   = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clock_sig,
    input  logic                       reset_sig,
    output logic                       in_ready,
    input  logic                       in_valid,
    input  logic [DATA_BITS-1:0]       in_data,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic                       busy,
    output logic                       txd
`ifdef PERIDOT_TXD_CTS_EN
    ,
    input  logic                       cts_n
`endif
);

    localparam int DIVNUM = CLOCK_FREQUENCY / UART_BAUDRATE - 1;
    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam logic [15:0]              DIV_RELOAD = 16'(DIVNUM);
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [3:0]               DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]               STOP_LAST  = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("peridot_phy_txd_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("peridot_phy_txd_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("peridot_phy_txd_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH_LOG2 < 1 || FIFO_DEPTH_LOG2 > 8) begin : g_bad_depth
        $error("peridot_phy_txd_fifo: FIFO_DEPTH_LOG2 must be 1..8");
    end
    if (DIVNUM < 0 || DIVNUM > 65535) begin : g_bad_divider
        $error("peridot_phy_txd_fifo: baud divider does not fit 16 bits");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    state_t                     state_q, state_d;
    logic [15:0]                div_q, div_d;
    logic [3:0]                 bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]       shift_q, shift_d;
    logic                       par_q, par_d;
    logic                       txd_q, txd_d;

    logic [DATA_BITS-1:0]       mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic [DATA_BITS-1:0]       fifo_head;

    logic push;
    logic pop;
    logic load;
    logic tick;
    logic cts_ok;
    logic start_ok;

`ifdef PERIDOT_TXD_CTS_EN
    logic cts_meta_q, cts_sync_q;

    // Both stages reset to "not clear" so no frame slips out before the line settles.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    assign cts_ok = ~cts_sync_q;
`else
    assign cts_ok = 1'b1;
`endif

    assign in_ready   = (count_q != FULL_LEVEL);
    assign push       = in_valid & in_ready;
    assign fifo_head  = mem_q[rd_ptr_q];
    assign start_ok   = (count_q != '0) & cts_ok;
    assign tick       = (div_q == 16'd0);
    assign fifo_level = count_q;
    assign busy       = (state_q != ST_IDLE) | (count_q != '0);
    assign txd        = txd_q;

    always_ff @(posedge clock_sig) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        txd_d     = txd_q;
        load      = 1'b0;

        if (state_q != ST_IDLE) begin
            div_d = tick ? DIV_RELOAD : div_q - 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                load  = start_ok;
            end
            ST_START: begin
                if (tick) begin
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        if (PARITY != 0) begin
                            txd_d   = par_q;
                            state_d = ST_PAR;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PAR: begin
                if (tick) begin
                    txd_d     = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        // Chain straight into the next start bit when more data is waiting.
                        load    = start_ok;
                        txd_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            txd_d     = 1'b0;
            state_d   = ST_START;
            div_d     = DIV_RELOAD;
            bit_cnt_d = '0;
            shift_d   = fifo_head;
            par_d     = (PARITY == 1) ? ~(^fifo_head) : (^fifo_head);
        end
    end

    assign pop = load;

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
            count_q   <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_peridot_phy_txd_fifo.sv
// Bench for peridot_phy_txd_fifo: three frame formats at 10 clocks per bit, table-driven frame
// checks plus streaming, push/pop collision, mid-frame reset and (PERIDOT_TXD_CTS_EN) flow control.
module tb_peridot_phy_txd_fifo;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_bc;
    logic [2:0] vld;
    logic [8:0] dat;
    logic [2:0] rdy;
    logic [2:0] txd_w;
    logic [2:0] busy_w;
    logic [4:0] lvl_a, lvl_b, lvl_c;
`ifdef PERIDOT_TXD_CTS_EN
    logic [2:0] cts;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          unit;
        logic [8:0]  data;
        int          nbits;
        logic [11:0] bits;
        string       name;
    } fvec_t;

    fvec_t      vecs [8];
    fvec_t      post_v;
    logic [7:0] exp_bytes [32];

    always #5 clk = ~clk;

    peridot_phy_txd_fifo #(
        .CLOCK_FREQUENCY(1000000), .UART_BAUDRATE(100000),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH_LOG2(4)
    ) dut_a (
        .clock_sig(clk), .reset_sig(rst_a), .in_ready(rdy[0]), .in_valid(vld[0]),
        .in_data(dat[7:0]), .fifo_level(lvl_a), .busy(busy_w[0]), .txd(txd_w[0])
`ifdef PERIDOT_TXD_CTS_EN
        , .cts_n(cts[0])
`endif
    );

    peridot_phy_txd_fifo #(
        .CLOCK_FREQUENCY(1000000), .UART_BAUDRATE(100000),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH_LOG2(4)
    ) dut_b (
        .clock_sig(clk), .reset_sig(rst_bc), .in_ready(rdy[1]), .in_valid(vld[1]),
        .in_data(dat[6:0]), .fifo_level(lvl_b), .busy(busy_w[1]), .txd(txd_w[1])
`ifdef PERIDOT_TXD_CTS_EN
        , .cts_n(cts[1])
`endif
    );

    peridot_phy_txd_fifo #(
        .CLOCK_FREQUENCY(1000000), .UART_BAUDRATE(100000),
        .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH_LOG2(4)
    ) dut_c (
        .clock_sig(clk), .reset_sig(rst_bc), .in_ready(rdy[2]), .in_valid(vld[2]),
        .in_data(dat[6:0]), .fifo_level(lvl_c), .busy(busy_w[2]), .txd(txd_w[2])
`ifdef PERIDOT_TXD_CTS_EN
        , .cts_n(cts[2])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input int unit, input logic [8:0] data,
                           input int nbits, input logic [11:0] bits, input string name);
        vecs[idx].unit  = unit;
        vecs[idx].data  = data;
        vecs[idx].nbits = nbits;
        vecs[idx].bits  = bits;
        vecs[idx].name  = name;
    endtask

    // Push one word into an idle unit and check latency, every line bit at mid-bit, and frame end.
    task automatic push_frame_check(input fvec_t v);
        @(negedge clk);
        vld[v.unit] = 1'b1;
        dat = v.data;
        @(negedge clk);
        vld[v.unit] = 1'b0;
        chk({v.name, "_pre_start"}, 32'(txd_w[v.unit]), 32'd1);
        chk({v.name, "_busy"}, 32'(busy_w[v.unit]), 32'd1);
        @(negedge clk);
        chk({v.name, "_start_latency"}, 32'(txd_w[v.unit]), 32'd0);
        repeat (5) @(negedge clk);
        for (int k = 0; k < v.nbits; k++) begin
            if (k > 0) repeat (10) @(negedge clk);
            chk($sformatf("%s_bit%0d", v.name, k), 32'(txd_w[v.unit]), 32'(v.bits[k]));
        end
        repeat (4) @(negedge clk);
        chk({v.name, "_busy_last_clock"}, 32'(busy_w[v.unit]), 32'd1);
        @(negedge clk);
        chk({v.name, "_idle_after_frame"}, 32'(busy_w[v.unit]), 32'd0);
        $display("frame %s data=%0h bits=%0d done", v.name, v.data, v.nbits);
    endtask

    // Decode n 8N1 frames from unit A against exp_bytes; optionally require zero idle between frames.
    task automatic rx_run(input int n, input bit b2b);
        logic [7:0] rx;
        for (int f = 0; f < n; f++) begin
            int guard = 0;
            while (txd_w[0] !== 1'b0 && guard < 400) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 400) begin
                chk($sformatf("rx%0d_start_timeout", f), 32'(txd_w[0]), 32'd0);
                return;
            end
            if (f > 0 && b2b) chk($sformatf("rx%0d_gap", f), 32'(guard), 32'd0);
            repeat (5) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (10) @(negedge clk);
                rx[k] = txd_w[0];
            end
            repeat (10) @(negedge clk);
            chk($sformatf("rx%0d_stop", f), 32'(txd_w[0]), 32'd1);
            chk($sformatf("rx%0d_data", f), 32'(rx), 32'(exp_bytes[f]));
            $display("rx frame %0d data=%0h", f, rx);
            repeat (5) @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vld = '0;
        dat = '0;
        rst_a = 1'b1;
        rst_bc = 1'b1;
`ifdef PERIDOT_TXD_CTS_EN
        cts = 3'b000;
`endif
        set_vec(0, 0, 9'h0A5, 10, 12'b0011_0100_1010, "a_A5");
        set_vec(1, 0, 9'h000, 10, 12'b0010_0000_0000, "a_00");
        set_vec(2, 0, 9'h0FF, 10, 12'b0011_1111_1110, "a_FF");
        set_vec(3, 1, 9'h041, 11, 12'b0110_1000_0010, "e_41");
        set_vec(4, 1, 9'h07F, 11, 12'b0111_1111_1110, "e_7F");
        set_vec(5, 1, 9'h02A, 11, 12'b0111_0101_0100, "e_2A");
        set_vec(6, 2, 9'h041, 11, 12'b0111_1000_0010, "o_41");
        set_vec(7, 2, 9'h000, 11, 12'b0111_0000_0000, "o_00");
        post_v.unit  = 0;
        post_v.data  = 9'h055;
        post_v.nbits = 10;
        post_v.bits  = 12'b0010_1010_1010;
        post_v.name  = "a_55_post_reset";

        repeat (3) @(negedge clk);
        chk("reset_txd_a", 32'(txd_w[0]), 32'd1);
        chk("reset_level_a", 32'(lvl_a), 32'd0);
        rst_a = 1'b0;
        rst_bc = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(rdy), 32'b111);
        chk("reset_busy", 32'(busy_w), 32'b000);
        chk("reset_txd", 32'(txd_w), 32'b111);
        chk("reset_levels", {17'd0, lvl_a, lvl_b, lvl_c}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            push_frame_check(vecs[i]);
        end

        // Streaming: 20 words with in_valid held high, FIFO fills to 16 while frames run back to back.
        for (int i = 0; i < 20; i++) exp_bytes[i] = 8'(i);
        fork
            begin
                int  idx = 0;
                int  guard = 0;
                bit  seen_full = 1'b0;
                logic r;
                while (idx < 20 && guard < 5000) begin
                    vld[0] = 1'b1;
                    dat = 9'(idx);
                    if (!rdy[0] && !seen_full) begin
                        seen_full = 1'b1;
                        chk("stream_full_level", 32'(lvl_a), 32'd16);
                        chk("stream_accepted_at_full", 32'(idx), 32'd17);
                    end
                    r = rdy[0];
                    @(negedge clk);
                    guard++;
                    if (r) idx++;
                end
                vld[0] = 1'b0;
                chk("stream_all_pushed", 32'(idx), 32'd20);
                chk("stream_full_seen", 32'(seen_full), 32'd1);
            end
            rx_run(20, 1'b1);
        join
        chk("stream_idle", 32'(busy_w[0]), 32'd0);
        $display("stream of 20 frames done");

        // Push lands on the same edge as the chained pop at the end of the first frame.
        exp_bytes[0] = 8'h31; exp_bytes[1] = 8'h32; exp_bytes[2] = 8'h33;
        exp_bytes[3] = 8'h34; exp_bytes[4] = 8'h35;
        fork
            begin
                vld[0] = 1'b1; dat = 9'h031;
                @(negedge clk); dat = 9'h032;
                @(negedge clk); dat = 9'h033;
                @(negedge clk); dat = 9'h034;
                @(negedge clk); vld[0] = 1'b0;
                chk("pp_fill_level", 32'(lvl_a), 32'd3);
                repeat (97) @(negedge clk);
                chk("pp_level_before", 32'(lvl_a), 32'd3);
                chk("pp_in_stop_bit", 32'(txd_w[0]), 32'd1);
                vld[0] = 1'b1; dat = 9'h035;
                @(negedge clk); vld[0] = 1'b0;
                chk("pp_level_after", 32'(lvl_a), 32'd3);
                chk("pp_next_start", 32'(txd_w[0]), 32'd0);
            end
            rx_run(5, 1'b1);
        join
        chk("pp_idle", 32'(busy_w[0]), 32'd0);
        $display("push/pop collision sequence done");

        // Reset in the middle of data bit 3 of the second of three queued frames.
        vld[0] = 1'b1; dat = 9'h061;
        @(negedge clk); dat = 9'h062;
        @(negedge clk); dat = 9'h063;
        @(negedge clk); vld[0] = 1'b0;
        repeat (144) @(negedge clk);
        chk("rst_pre_busy", 32'(busy_w[0]), 32'd1);
        chk("rst_pre_data_bit3", 32'(txd_w[0]), 32'd0);
        chk("rst_pre_level", 32'(lvl_a), 32'd1);
        rst_a = 1'b1;
        #1;
        chk("rst_async_txd", 32'(txd_w[0]), 32'd1);
        chk("rst_async_level", 32'(lvl_a), 32'd0);
        chk("rst_async_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_async_ready", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stays_idle_txd", 32'(txd_w[0]), 32'd1);
        chk("rst_stays_idle_busy", 32'(busy_w[0]), 32'd0);
        $display("mid-frame reset done");
        push_frame_check(post_v);

`ifdef PERIDOT_TXD_CTS_EN
        begin
            int n;
            cts[0] = 1'b1;
            repeat (3) @(negedge clk);
            vld[0] = 1'b1; dat = 9'h012;
            @(negedge clk); vld[0] = 1'b0;
            repeat (20) @(negedge clk);
            chk("cts_hold_txd", 32'(txd_w[0]), 32'd1);
            chk("cts_hold_busy", 32'(busy_w[0]), 32'd1);
            chk("cts_hold_level", 32'(lvl_a), 32'd1);
            cts[0] = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("cts_sync_delay", 32'(txd_w[0]), 32'd1);
            @(negedge clk);
            chk("cts_start", 32'(txd_w[0]), 32'd0);
            vld[0] = 1'b1; dat = 9'h034;
            @(negedge clk); vld[0] = 1'b0;
            chk("cts_queued", 32'(lvl_a), 32'd1);
            repeat (40) @(negedge clk);
            cts[0] = 1'b1;
            repeat (54) @(negedge clk);
            chk("cts_frame_stop", 32'(txd_w[0]), 32'd1);
            repeat (5) @(negedge clk);
            chk("cts_withheld_txd", 32'(txd_w[0]), 32'd1);
            chk("cts_withheld_level", 32'(lvl_a), 32'd1);
            repeat (30) @(negedge clk);
            chk("cts_still_withheld", 32'(txd_w[0]), 32'd1);
            chk("cts_still_busy", 32'(busy_w[0]), 32'd1);
            cts[0] = 1'b0;
            n = 0;
            while (txd_w[0] !== 1'b0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("cts_release_latency", 32'(n), 32'd3);
            n = 0;
            while (busy_w[0] !== 1'b0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("cts_final_idle", 32'(busy_w[0]), 32'd0);
            $display("cts flow control sequence done");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/peridot_phy_txd_fifo.md
Name: peridot_phy_txd_fifo

Overview:
Parametrised UART transmit PHY. It is the next generation of the fixed 8N1 sender and accepts bytes over an Avalon-ST style sink into a small FIFO. Frame format is selectable at build time: data bits, parity and stop bits. The block sits between the PERIDOT host bridge / peripheral core and the board TXD pin, and sustains back-to-back frames with no idle gap between them.

Parameters:
CLOCK_FREQUENCY, 50000000, clock_sig frequency in Hz
UART_BAUDRATE, 115200, line rate in bit/s; bit period DIVNUM+1 clocks, DIVNUM = CLOCK_FREQUENCY/UART_BAUDRATE - 1 (integer divide)
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits, legal 1 or 2
FIFO_DEPTH_LOG2, 4, FIFO depth = 2**FIFO_DEPTH_LOG2 entries (legal 1..8)

Ports:
clock_sig  in  1  module clock, all logic rising-edge
reset_sig  in  1  asynchronous, active-high reset
in_ready  out  1  sink ready: 1 when FIFO not full
in_valid  in  1  sink valid
in_data  in  DATA_BITS  character to send
fifo_level  out  FIFO_DEPTH_LOG2+1  entries currently held in FIFO
busy  out  1  1 while FIFO non-empty or a frame is on the line
txd  out  1  serial output, idle high, registered
cts_n  in  1  clear-to-send, active low (present only with PERIDOT_TXD_CTS_EN)

Behaviour:
- Reset (asynchronous, any time, including mid-frame): txd=1, in_ready=1, fifo_level=0, busy=0, FIFO emptied, state IDLE, counters 0. A frame in progress is truncated immediately.
- Divider: 16-bit down-counter reloaded with DIVNUM at every bit boundary. Every bit, including start, parity and each stop bit, lasts exactly DIVNUM+1 clocks.
- Push: a word is written on a rising edge where in_valid=1 and in_ready=1. When full, in_ready=0 and in_valid is ignored. in_data does not need to be held after acceptance.
- Push and pop on the same edge: both occur and fifo_level is unchanged.
- FIFO is first-in first-out, circular pointers that wrap modulo depth. fifo_level reaches 2**FIFO_DEPTH_LOG2 when full.
- State machine:
  - IDLE: txd=1. If FIFO is non-empty (and permitted by CTS, see Optional Feature), pop the head on the next edge, set txd=0 and go to START.
  - START: after one bit period go to DATA, driving data bit 0.
  - DATA: shift LSB first. After DATA_BITS periods go to PAR if PARITY!=0, else STOP.
  - PAR: drive the parity bit. Odd = XNOR-reduce of the data; even = XOR-reduce of the data. After one period go to STOP.
  - STOP: txd=1 for STOP_BITS periods. On the final clock of the last stop bit: if FIFO is non-empty (and permitted), pop, set txd=0 and go to START with zero idle gap; otherwise go to IDLE.
- Latency: word accepted on edge E0 into an empty FIFO with the state machine in IDLE gives txd=0 after edge E0+1.
- busy = (state != IDLE) or (fifo_level != 0).
- Frame length in clocks = (DIVNUM+1) * (1 + DATA_BITS + (PARITY!=0) + STOP_BITS).
- Illegal parameter values are unsupported. The implementation flags them with a simulation-only $error.

Optional Feature:
- Macro PERIDOT_TXD_CTS_EN.
- Defined:
  - cts_n port exists and is synchronised through 2 flip-flops.
  - A new frame (pop from IDLE or STOP) starts only when the synchronised cts_n=0.
  - A frame already started always completes regardless of cts_n.
  - While cts_n=1 the state machine holds in IDLE with txd=1.
- Undefined: no cts_n port; frames start whenever the FIFO is non-empty.

Test Plan:
- CLOCK_FREQUENCY=1000000, UART_BAUDRATE=100000, defaults. Push 0xA5 -> txd low 1 clock after acceptance, then line bits 0,1,0,1,0,0,1,0,1,1 at 10 clocks each; busy drops after 100 clocks.
- Same clocking, DATA_BITS=7, PARITY=2, STOP_BITS=2. Push 0x41 -> frame 0,1,0,0,0,0,0,1,0,1,1, 110 clocks total. Repeat with PARITY=1 -> parity bit 1.
- Hold in_valid=1 with data 0..19, FIFO_DEPTH_LOG2=4:
  - in_ready deasserts when fifo_level=16 (the 17th word is accepted once the first frame starts).
  - All 20 bytes appear in order.
  - No idle clock between stop and start bits.
- Push on the same edge the state machine pops (fifo_level=3) -> fifo_level stays 3, and no data is lost or duplicated.
- Assert reset_sig for 1 clock mid-data-bit of the second of three queued frames -> txd=1, fifo_level=0, busy=0 immediately. Push 0x55 afterwards -> clean frame.
- With PERIDOT_TXD_CTS_EN defined:
  - cts_n=1, push 0x12 -> txd stays 1, busy=1.
  - Drop cts_n -> start bit 3 clocks later (2-FF sync plus pop).
  - Raise cts_n mid-frame -> frame completes, next queued frame withheld.
